// File: rtl/led_pkg.sv
// Shared LED link definitions: brightness codes consumed by the LED driver
// and the PWM receive-side state encoding.
package led_pkg;

  localparam logic [2:0] LVL_0 = 3'd0;
  localparam logic [2:0] LVL_1 = 3'd1;
  localparam logic [2:0] LVL_2 = 3'd2;
  localparam logic [2:0] LVL_3 = 3'd3;
  localparam logic [2:0] LVL_4 = 3'd4;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } dec_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchroniser for an asynchronous PWM pin with rising-edge detect.
module pwm_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_level_decoder.sv
// Recovers the 0..4 brightness code from a PWM waveform by comparing high time
// against period each cycle, and flags a line that stops toggling.
module pwm_level_decoder
  import led_pkg::*;
#(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned TIMEOUT     = 4000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ipwm_in,
  output logic [2:0] olevel,
  output logic       ovalid,
  output logic       ostuck
);

  localparam int unsigned      CMP_W     = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic s;
  logic rise;

  pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ipwm_in),
    .level  (s),
    .rise_c (rise)
  );

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] p_lat_q, p_lat_d;
  logic [CNT_W-1:0] h_lat_q, h_lat_d;
  logic             calc_q, calc_d;
  logic [2:0]       olevel_d;
  logic             ovalid_d;
  logic             ostuck_d;

  // Divider-free quantisation: 8H against odd multiples of P rounds H/P to quarters
  logic [CMP_W-1:0] h8, p1, p3, p5, p7;
  logic [2:0]       level_c;

  always_comb begin
    h8      = {h_lat_q, 3'b000};
    p1      = CMP_W'(p_lat_q);
    p3      = p1 + (p1 << 1);
    p5      = p1 + (p1 << 2);
    p7      = (p1 << 3) - p1;
    level_c = 3'(h8 >= p1) + 3'(h8 >= p3) + 3'(h8 >= p5) + 3'(h8 >= p7);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      p_lat_q  <= '0;
      h_lat_q  <= '0;
      calc_q   <= 1'b0;
      olevel   <= LVL_0;
      ovalid   <= 1'b0;
      ostuck   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      p_lat_q  <= p_lat_d;
      h_lat_q  <= h_lat_d;
      calc_q   <= calc_d;
      olevel   <= olevel_d;
      ovalid   <= ovalid_d;
      ostuck   <= ostuck_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    p_lat_d  = p_lat_q;
    h_lat_d  = h_lat_q;
    calc_d   = 1'b0;
    olevel_d = olevel;
    ovalid_d = 1'b0;
    ostuck_d = ostuck;

    // Result of the period latched on the previous edge
    if (calc_q) begin
      olevel_d = level_c;
      ovalid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        period_d = '0;
        high_d   = '0;
        if (rise) begin
          state_d  = MEASURE;
          period_d = CNT_W'(1);
          high_d   = CNT_W'(1);
          ostuck_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          p_lat_d  = period_q;
          h_lat_d  = high_q;
          calc_d   = 1'b1;
          period_d = CNT_W'(1);
          high_d   = CNT_W'(1);
          ostuck_d = 1'b0;
        end else if (period_q == TIMEOUT_C) begin
          olevel_d = s ? LVL_4 : LVL_0;
          ovalid_d = 1'b1;
          ostuck_d = 1'b1;
          state_d  = IDLE;
          period_d = '0;
          high_d   = '0;
        end else begin
          if (period_q != CNT_MAX) period_d = period_q + CNT_W'(1);
          if (s && high_q != CNT_MAX) high_d = high_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Directed bench for pwm_level_decoder: duty sweep, long period, reset,
// stuck-low/high timeouts and an edge landing on the timeout count.
module tb_pwm_level_decoder;

  localparam int unsigned CNT_W       = 12;
  localparam int unsigned TIMEOUT     = 4000;
  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ipwm_in;
  logic [2:0] olevel;
  logic       ovalid;
  logic       ostuck;

  int ncomp = 0;
  int nfail = 0;

  int vpos_q[$];
  int vlvl_q[$];
  int vstk_q[$];
  int stk0_idx;

  always #5 clk = ~clk;

  pwm_level_decoder #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ipwm_in (ipwm_in),
    .olevel  (olevel),
    .ovalid  (ovalid),
    .ostuck  (ostuck)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Drive one clock cycle and leave time just past the edge for sampling
  task automatic cyc(input logic v);
    ipwm_in = v;
    @(posedge clk);
    #1;
  endtask

  // One PWM period: h cycles high then p-h low, logging every ovalid pulse
  task automatic run_period(input int p, input int h);
    vpos_q.delete();
    vlvl_q.delete();
    vstk_q.delete();
    stk0_idx = -1;
    for (int i = 0; i < p; i++) begin
      cyc(i < h);
      if (ovalid === 1'b1) begin
        vpos_q.push_back(i);
        vlvl_q.push_back(int'(olevel));
        vstk_q.push_back(int'(ostuck));
      end
      if (stk0_idx < 0 && ostuck === 1'b0) stk0_idx = i;
    end
  endtask

  task automatic check_one(input string tag, input int lvl);
    check({tag, "_cnt"}, vpos_q.size(), 1);
    check({tag, "_pos"}, qget(vpos_q, 0), SYNC_STAGES + 1);
    check({tag, "_lvl"}, qget(vlvl_q, 0), lvl);
  endtask

  initial begin
    int total;
    int bad;

    rst     = 1'b1;
    ipwm_in = 1'b0;
    repeat (3) cyc(1'b0);
    check("rst_olevel", olevel, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_ostuck", ostuck, 0);
    rst = 1'b0;

    // Duty sweep at period 8; each period reports the previous one
    run_period(8, 1);
    check("first_edge_cnt", vpos_q.size(), 0);
    run_period(8, 3);
    check_one("duty_h1", 1);
    run_period(8, 5);
    check_one("duty_h3", 2);
    run_period(8, 7);
    check_one("duty_h5", 3);
    run_period(8, 1);
    check_one("duty_h7", 4);

    // Reset in the middle of a measurement, after olevel has become 1
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check("pre_rst_olevel", olevel, 1);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    check("midrst_olevel", olevel, 0);
    check("midrst_ovalid", ovalid, 0);
    check("midrst_ostuck", ostuck, 0);
    run_period(8, 4);
    check("postrst_edge1_cnt", vpos_q.size(), 0);
    run_period(8, 4);
    check_one("postrst_h4", 2);

    // Long period 1000 / high 600
    total = 0;
    bad   = 0;
    for (int k = 0; k < 11; k++) begin
      run_period(1000, 600);
      if (k > 0) begin
        total += vpos_q.size();
        foreach (vlvl_q[j]) if (vlvl_q[j] != 2) bad++;
      end
    end
    check("long_pulses", total, 10);
    check("long_non_lvl2", bad, 0);
    check("long_pos", qget(vpos_q, 0), SYNC_STAGES + 1);

    // Stuck low after one edge
    run_period(TIMEOUT + 10, 1);
    check("stklo_cnt", vpos_q.size(), 2);
    check("stklo_prev_lvl", qget(vlvl_q, 0), 2);
    check("stklo_pos", qget(vpos_q, 1), TIMEOUT + 2);
    check("stklo_lvl", qget(vlvl_q, 1), 0);
    check("stklo_stk_at_pulse", qget(vstk_q, 1), 1);
    check("stklo_stk_end", ostuck, 1);

    // Restore PWM: stuck clears at the first edge, output needs a second edge
    run_period(8, 4);
    check("restore_cnt", vpos_q.size(), 0);
    check("restore_stk_fall", stk0_idx, SYNC_STAGES);
    run_period(8, 4);
    check_one("restore_h4", 2);

    // Stuck high
    run_period(TIMEOUT + 10, TIMEOUT + 10);
    check("stkhi_cnt", vpos_q.size(), 2);
    check("stkhi_pos", qget(vpos_q, 1), TIMEOUT + 2);
    check("stkhi_lvl", qget(vlvl_q, 1), 4);
    check("stkhi_stk_at_pulse", qget(vstk_q, 1), 1);
    run_period(200, 200);
    check("stkhi_hold_cnt", vpos_q.size(), 0);
    check("stkhi_hold_stk", ostuck, 1);

    // Period exactly TIMEOUT: edge coincides with the timeout count
    run_period(4, 0);
    check("coin_low_cnt", vpos_q.size(), 0);
    run_period(TIMEOUT, TIMEOUT / 2);
    check("coin_start_cnt", vpos_q.size(), 0);
    check("coin_stk_fall", stk0_idx, SYNC_STAGES);
    run_period(TIMEOUT, TIMEOUT / 2);
    check_one("coin_half", 2);
    check("coin_stk_end", ostuck, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/pwm_level_decoder.md
# pwm_level_decoder

Receive side of the LED PWM link: samples a single-bit PWM waveform and recovers the 3-bit brightness code (0–4) that the LED driver consumes on `ipwm`. Sits between an external or looped-back PWM pin and the control logic. Measures high time against period each cycle, quantises the ratio to the nearest of five levels, and flags a stuck line.

## Interface
Parameters:
- `CNT_W`, 12, width of high/period counters
- `TIMEOUT`, 4000, cycles without a rising edge before stuck detection; must be ≤ 2^CNT_W − 1
- `SYNC_STAGES`, 2, input synchroniser depth, ≥ 2

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ipwm_in`  in  1  PWM waveform, asynchronous to `clk`
- `olevel`  out  3  recovered level, 3'd0..3'd4, held between updates
- `ovalid`  out  1  one-cycle pulse when `olevel` is updated
- `ostuck`  out  1  high while the line is considered stuck

## Operation
- `ipwm_in` passes through `SYNC_STAGES` flops; a rising edge (`s` = 1, previous `s` = 0) marks the period boundary.
- States: IDLE, MEASURE.
- IDLE: counters cleared; on a rising edge go to MEASURE with `period_cnt` = 1, `high_cnt` = 1; no output.
- MEASURE, each cycle without an edge: `period_cnt`++; `high_cnt`++ if `s` = 1; both saturate at 2^CNT_W − 1.
- MEASURE, on a rising edge: latch P = `period_cnt`, H = `high_cnt`, reload both to 1, stay in MEASURE, and compute the level in the next cycle.
- Level quantisation, without a divider: compare 8H against P, 3P, 5P, and 7P at CNT_W+3 bits. Level = number of thresholds with 8H ≥ threshold, giving 0..4. Ties round up.
- Timeout: in MEASURE, if `period_cnt` reaches `TIMEOUT` with no edge:
  - `olevel` = 0 if `s` = 0, else 4
  - pulse `ovalid`, set `ostuck`, go to IDLE
- `ostuck` clears on the next rising edge. That edge starts a fresh measurement and does not produce an output.
- An edge and a timeout in the same cycle: the edge wins and no timeout is taken.
- Reset (any cycle, including mid-measurement): `olevel` = 0, `ovalid` = 0, `ostuck` = 0, state IDLE, counters 0, synchroniser flops 0.

## Timing
- `ipwm_in` rising, first sampled high at clk edge N: the synchronised edge is detected in cycle N+SYNC_STAGES.
- `olevel`/`ovalid` update registered at edge N+SYNC_STAGES+1.
- The first valid output requires two rising edges after reset or after a stuck condition.
- `ovalid` is never high for two consecutive cycles unless the period P ≤ 1. The minimum supported period is 2 cycles; shorter periods give undefined levels.
- Throughput: one result per PWM period.

## Structure
- Shared package `led_pkg`:
  - level constants `LVL_0`..`LVL_4` (3'd0..3'd4), identical to the LED driver's `ipwm` codes
  - state encoding IDLE/MEASURE
- Sub-module `pwm_sync_edge`: parameterised synchroniser plus rising-edge detect. Outputs are the synchronised level and a one-cycle rise pulse.
- Counters, FSM, threshold comparators, and output registers stay in the top module.

## Test plan
- Reset mid-measurement: assert `rst` for 1 cycle during MEASURE → the next cycle shows `olevel` = 0, `ovalid` = 0, `ostuck` = 0. Two further rising edges are needed before `ovalid`.
- Duty sweep, period 8:
  - H = 1 → 8 vs 8 → level 1
  - H = 3 → 24 vs 3P = 24 → level 2 (tie rounds up)
  - H = 5 → 40 vs 5P = 40 → level 3
  - H = 7 → 56 vs 7P = 56 → level 4
  - each result appears exactly SYNC_STAGES+1 cycles after the edge, as a single `ovalid` pulse
- Long period, 1000 cycles, H = 600: 8H = 4800 vs thresholds 1000/3000/5000/7000 → level 2. Repeat for 10 periods → 10 `ovalid` pulses, all level 2.
- Stuck low: hold `ipwm_in` = 0 after one edge → `ovalid` pulse with `olevel` = 0 and `ostuck` = 1 exactly `TIMEOUT` counts after the edge. On restoring PWM, `ostuck` falls at the first edge.
- Stuck high: hold `ipwm_in` = 1 → timeout gives `olevel` = 4 and `ostuck` = 1. No further `ovalid` while it stays held.
- Edge coinciding with `period_cnt` = `TIMEOUT`: no timeout and no `ostuck`; a normal level is reported.
